// File: rtl/si_reply_framer.sv
// si_reply_framer
//   Buffers each SI byte burst (one contiguous run of si_din_en high) and then
//   emits one reply frame per burst: sync word (MSB byte first), 16-bit length
//   {trunc, len[14:0]}, the stored payload and an XOR checksum of that payload.
//   A burst that starts while a frame is still pending is dropped and counted.
//
// Ports
//   clk           in   1  system clock
//   rst           in   1  synchronous active-high reset
//   si_din        in   8  SI byte from the SI-get block
//   si_din_en     in   1  byte valid; a high run is one burst
//   reply_dout    out  8  framed reply byte, registered, 8'h00 when not valid
//   reply_dout_en out  1  reply byte valid, high for the whole frame
//   frame_drop    out  1  one-cycle pulse when a burst is dropped
//   drop_cnt      out  8  dropped-burst count, saturating at 8'hFF
module si_reply_framer #(
   parameter int unsigned AW         = 11,
   parameter int unsigned MAX_LEN    = 1024,
   parameter logic [15:0] SYNC_WORD  = 16'h55AA,
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] si_din,
   input  logic       si_din_en,
   output logic [7:0] reply_dout,
   output logic       reply_dout_en,
   output logic       frame_drop,
   output logic [7:0] drop_cnt
);

   localparam logic [15:0] MaxLen  = 16'(MAX_LEN);
   localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

   // Each state names what reply_dout is showing during that cycle.
   typedef enum logic [2:0] {
      StIdle, StCapture, StHdr, StPayload, StCsum, StGap
   } state_t;

   state_t      state;
   logic [7:0]  mem [2**AW];
   logic [15:0] len;
   logic        trunc;
   logic        dropping;
   logic        en_prev;
   logic [7:0]  csum;
   logic [1:0]  hcnt;
   logic [15:0] pcnt;
   logic [15:0] gcnt;

   logic          busy;
   logic          drop_start;
   logic          accept;
   logic          store;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [15:0]   pnext;
   logic [15:0]   len_field;
   logic [7:0]    hdr_next;

   always_comb begin
      busy       = (state == StHdr) || (state == StPayload) ||
                   (state == StCsum) || (state == StGap);
      drop_start = si_din_en && !en_prev && busy;
      accept     = (state == StIdle) && si_din_en && !dropping;
      store      = (state == StCapture) && si_din_en && (len < MaxLen);
      wr_en      = accept || store;
      wr_addr    = accept ? '0 : AW'(len);
      pnext      = pcnt + 16'd1;
      // Address 0 is read while the last header byte is on the output.
      rd_addr    = (state == StHdr) ? '0 : AW'(pnext);
      len_field  = {trunc, len[14:0]};
      hdr_next   = 8'h00;
      case (hcnt)
         2'd0:    hdr_next = SYNC_WORD[7:0];
         2'd1:    hdr_next = len_field[15:8];
         default: hdr_next = len_field[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= si_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         len           <= '0;
         trunc         <= 1'b0;
         dropping      <= 1'b0;
         en_prev       <= 1'b0;
         csum          <= '0;
         hcnt          <= '0;
         pcnt          <= '0;
         gcnt          <= '0;
         reply_dout    <= '0;
         reply_dout_en <= 1'b0;
         frame_drop    <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         en_prev <= si_din_en;

         // A dropped burst stays ignored until its en run ends, even across IDLE.
         if (drop_start) begin
            dropping   <= 1'b1;
            frame_drop <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end else begin
            frame_drop <= 1'b0;
            if (!si_din_en) begin
               dropping <= 1'b0;
            end
         end

         case (state)
            StIdle: begin
               if (accept) begin
                  len   <= 16'd1;
                  trunc <= 1'b0;
                  csum  <= si_din;
                  state <= StCapture;
               end
            end
            StCapture: begin
               if (si_din_en) begin
                  if (store) begin
                     len  <= len + 16'd1;
                     csum <= csum ^ si_din;
                  end else begin
                     trunc <= 1'b1;
                  end
               end else begin
                  hcnt          <= '0;
                  reply_dout    <= SYNC_WORD[15:8];
                  reply_dout_en <= 1'b1;
                  state         <= StHdr;
               end
            end
            StHdr: begin
               if (hcnt == 2'd3) begin
                  reply_dout <= mem[rd_addr];
                  pcnt       <= '0;
                  state      <= StPayload;
               end else begin
                  reply_dout <= hdr_next;
                  hcnt       <= hcnt + 2'd1;
               end
            end
            StPayload: begin
               if (pcnt == len - 16'd1) begin
                  reply_dout <= csum;
                  state      <= StCsum;
               end else begin
                  reply_dout <= mem[rd_addr];
                  pcnt       <= pnext;
               end
            end
            StCsum: begin
               reply_dout    <= '0;
               reply_dout_en <= 1'b0;
               gcnt          <= '0;
               state         <= StGap;
            end
            StGap: begin
               if (gcnt == GapLast) begin
                  state <= StIdle;
               end else begin
                  gcnt <= gcnt + 16'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_si_reply_framer.sv
// tb_si_reply_framer
//   Directed bench for si_reply_framer: drives SI bursts, collects every
//   reply byte and compares the frames with expected frames built here.
module tb_si_reply_framer;

   localparam int MaxLen = 1024;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] si_din;
   logic       si_din_en;
   logic [7:0] reply_dout;
   logic       reply_dout_en;
   logic       frame_drop;
   logic [7:0] drop_cnt;

   si_reply_framer dut (
      .clk           (clk),
      .rst           (rst),
      .si_din        (si_din),
      .si_din_en     (si_din_en),
      .reply_dout    (reply_dout),
      .reply_dout_en (reply_dout_en),
      .frame_drop    (frame_drop),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] tx_q[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int frames   = 0;
   int drops    = 0;
   int idle_bad = 0;
   int rise_cyc = 0;
   int last_cyc = 0;
   logic en_d = 1'b0;

   // Reply collector, sampling on the falling edge.
   always @(negedge clk) begin
      if (reply_dout_en) begin
         got_q.push_back(reply_dout);
         if (!en_d) begin
            frames   = frames + 1;
            rise_cyc = cyc;
         end
      end else if (reply_dout !== 8'h00) begin
         idle_bad = idle_bad + 1;
      end
      if (frame_drop) drops = drops + 1;
      en_d = reply_dout_en;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Returns so that the next tick() lands in cycle c.
   task automatic idle_to(input int c);
      while (cyc < c - 1) tick();
   endtask

   task automatic send_burst();
      foreach (tx_q[i]) begin
         tick();
         si_din    = tx_q[i];
         si_din_en = 1'b1;
         last_cyc  = cyc;
      end
      tick();
      si_din_en = 1'b0;
      si_din    = 8'h00;
   endtask

   task automatic clear_obs();
      got_q.delete();
      frames = 0;
      drops  = 0;
   endtask

   // Expected frame from tx_q: payload truncated to MaxLen, trunc flag in LEN[15].
   task automatic build_exp();
      int n;
      logic [7:0] c;
      logic [15:0] lenf;
      n    = (tx_q.size() > MaxLen) ? MaxLen : tx_q.size();
      lenf = {(tx_q.size() > MaxLen) ? 1'b1 : 1'b0, 15'(n)};
      c    = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(lenf[15:8]);
      exp_q.push_back(lenf[7:0]);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(tx_q[i]);
         c = c ^ tx_q[i];
      end
      exp_q.push_back(c);
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_size"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      si_din    = 8'h00;
      si_din_en = 1'b0;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      check("rst_dout", reply_dout, 8'h00);
      check("rst_en", reply_dout_en, 1'b0);
      check("rst_drop", frame_drop, 1'b0);
      check("rst_cnt", drop_cnt, 8'h00);
      clear_obs();

      // 1: four-byte burst, latency and contiguity.
      tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_burst();
      idle(30);
      exp_q = '{8'h55, 8'hAA, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      compare_frame("t1");
      check("t1_frames", frames, 1);
      check("t1_latency", rise_cyc, last_cyc + 2);
      clear_obs();

      // 2: single byte.
      tx_q = '{8'hFF};
      send_burst();
      idle(30);
      exp_q = '{8'h55, 8'hAA, 8'h00, 8'h01, 8'hFF, 8'hFF};
      compare_frame("t2");
      check("t2_frames", frames, 1);
      check("t2_drops", drops, 0);
      clear_obs();

      // 3: oversize burst is truncated and flagged.
      tx_q.delete();
      for (int i = 0; i < MaxLen + 5; i++) tx_q.push_back(8'(i));
      send_burst();
      idle(MaxLen + 40);
      build_exp();
      compare_frame("t3");
      if (got_q.size() > 3) begin
         check("t3_lenhi", got_q[2], 8'h84);
         check("t3_lenlo", got_q[3], 8'h00);
      end
      check("t3_frames", frames, 1);
      clear_obs();

      // 4: burst during PAYLOAD of the previous frame is dropped.
      tx_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
      send_burst();
      build_exp();
      idle_to(last_cyc + 8);
      tx_q = '{8'hC1, 8'hC2, 8'hC3};
      send_burst();
      idle(40);
      compare_frame("t4");
      check("t4_frames", frames, 1);
      check("t4_drops", drops, 1);
      check("t4_cnt", drop_cnt, 8'd1);
      clear_obs();

      // 5a: burst spanning the GAP->IDLE boundary is dropped whole.
      tx_q = '{8'h10, 8'h20};
      send_burst();
      build_exp();
      idle_to(last_cyc + 14);
      tx_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
      send_burst();
      idle(40);
      compare_frame("t5a");
      check("t5a_frames", frames, 1);
      check("t5a_drops", drops, 1);
      check("t5a_cnt", drop_cnt, 8'd2);
      clear_obs();

      // 5b: burst starting on the last GAP cycle is dropped too.
      tx_q = '{8'h5C};
      send_burst();
      build_exp();
      idle_to(last_cyc + 15);
      tx_q = '{8'hE1, 8'hE2};
      send_burst();
      idle(40);
      compare_frame("t5b");
      check("t5b_frames", frames, 1);
      check("t5b_cnt", drop_cnt, 8'd3);
      clear_obs();

      // 5c: next burst after idle is framed normally.
      tx_q = '{8'h0F, 8'hF0, 8'h33};
      send_burst();
      idle(30);
      exp_q = '{8'h55, 8'hAA, 8'h00, 8'h03, 8'h0F, 8'hF0, 8'h33, 8'hCC};
      compare_frame("t5c");
      check("t5c_drops", drops, 0);
      clear_obs();

      // 6: reset mid-PAYLOAD aborts the frame and clears the drop count.
      tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_burst();
      idle_to(last_cyc + 8);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("t6_en_after_rst", reply_dout_en, 1'b0);
      check("t6_cnt_after_rst", drop_cnt, 8'd0);
      idle(20);
      check("t6_no_resume", reply_dout_en, 1'b0);
      clear_obs();
      tx_q = '{8'hAA, 8'hBB};
      send_burst();
      idle(30);
      exp_q = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h11};
      compare_frame("t6");
      check("t6_frames", frames, 1);

      check("idle_dout_zero", idle_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
